// File: rtl/ysyx_22040895_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040895_alu_arbiter
// Purpose  : Round-robin share of one combinational ALU between two requesters,
//            with a one-entry tagged response register (1-cycle latency).
// Options  : YSYX_22040895_ALU_ARB_STAT_EN adds grant/stall statistics counters.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_22040895_alu_arbiter #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   // requester 0 (EXU integer ops)
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [3:0]        req0_aluop_i,
   input  logic [DATA_W-1:0] req0_op1_i,
   input  logic [DATA_W-1:0] req0_op2_i,
   input  logic              req0_shift_i,
   // requester 1 (branch/compare unit)
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [3:0]        req1_aluop_i,
   input  logic [DATA_W-1:0] req1_op1_i,
   input  logic [DATA_W-1:0] req1_op2_i,
   input  logic              req1_shift_i,
   // shared ALU
   output logic [3:0]        alu_aluop_o,
   output logic [DATA_W-1:0] alu_op1_o,
   output logic [DATA_W-1:0] alu_op2_o,
   output logic              alu_shift_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_lt_i,
   input  logic              alu_ltu_i,
   input  logic              alu_zero_i,
   // response
   output logic              rsp_valid_o,
   output logic              rsp_id_o,
   output logic [DATA_W-1:0] rsp_result_o,
   output logic [2:0]        rsp_flags_o,
   input  logic              rsp_ready_i
`ifdef YSYX_22040895_ALU_ARB_STAT_EN
   ,
   output logic [CNT_W-1:0]  stat_grant0_o,
   output logic [CNT_W-1:0]  stat_grant1_o,
   output logic [CNT_W-1:0]  stat_stall_o
`endif
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic [2:0]        rsp_flags_q, rsp_flags_d;

   logic slot_free;
   logic drain;
   logic any_valid;
   logic grant_vld;
   logic grant_id;

   if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
      $error("ysyx_22040895_alu_arbiter: DATA_W and CNT_W must be non-zero");
   end

   // Pass-through drain: a leaving response frees the slot in the same cycle.
   always_comb begin
      slot_free = (state_q == ST_EMPTY) || rsp_ready_i;
      drain     = (state_q == ST_FULL) && rsp_ready_i;
      any_valid = req0_valid_i || req1_valid_i;
      grant_vld = slot_free && any_valid && !rst;
      if (req0_valid_i && req1_valid_i) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req1_valid_i;
      end
      req0_ready_o = grant_vld && !grant_id;
      req1_ready_o = grant_vld &&  grant_id;
   end

   // Idle cycles drive zeros so the ALU output is deterministic.
   always_comb begin
      alu_aluop_o = 4'b0000;
      alu_op1_o   = '0;
      alu_op2_o   = '0;
      alu_shift_o = 1'b0;
      if (req0_ready_o) begin
         alu_aluop_o = req0_aluop_i;
         alu_op1_o   = req0_op1_i;
         alu_op2_o   = req0_op2_i;
         alu_shift_o = req0_shift_i;
      end else if (req1_ready_o) begin
         alu_aluop_o = req1_aluop_i;
         alu_op1_o   = req1_op1_i;
         alu_op2_o   = req1_op2_i;
         alu_shift_o = req1_shift_i;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      if (grant_vld) begin
         state_d      = ST_FULL;
         last_grant_d = grant_id;
         rsp_id_d     = grant_id;
         rsp_result_d = alu_result_i;
         rsp_flags_d  = {alu_lt_i, alu_ltu_i, alu_zero_i};
      end else if (drain) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_EMPTY;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_flags_q  <= 3'b000;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
      end
   end

   assign rsp_valid_o  = (state_q == ST_FULL);
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_flags_o  = rsp_flags_q;

`ifdef YSYX_22040895_ALU_ARB_STAT_EN
   logic [CNT_W-1:0] stat_grant0_q, stat_grant0_d;
   logic [CNT_W-1:0] stat_grant1_q, stat_grant1_d;
   logic [CNT_W-1:0] stat_stall_q,  stat_stall_d;

   // Counters wrap naturally at 2^CNT_W.
   always_comb begin
      stat_grant0_d = stat_grant0_q;
      stat_grant1_d = stat_grant1_q;
      stat_stall_d  = stat_stall_q;
      if (req0_ready_o) begin
         stat_grant0_d = stat_grant0_q + CNT_W'(1);
      end
      if (req1_ready_o) begin
         stat_grant1_d = stat_grant1_q + CNT_W'(1);
      end
      if (any_valid && !slot_free) begin
         stat_stall_d = stat_stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grant0_q <= '0;
         stat_grant1_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_grant0_q <= stat_grant0_d;
         stat_grant1_q <= stat_grant1_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   assign stat_grant0_o = stat_grant0_q;
   assign stat_grant1_o = stat_grant1_q;
   assign stat_stall_o  = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040895_alu_arbiter.sv
`default_nettype none
// Directed bench for ysyx_22040895_alu_arbiter; a small ALU model closes the loop.
module tb_ysyx_22040895_alu_arbiter;
   localparam int DATA_W = 64;
   localparam int CNT_W  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid_i, req0_ready_o, req0_shift_i;
   logic [3:0]        req0_aluop_i;
   logic [DATA_W-1:0] req0_op1_i, req0_op2_i;
   logic              req1_valid_i, req1_ready_o, req1_shift_i;
   logic [3:0]        req1_aluop_i;
   logic [DATA_W-1:0] req1_op1_i, req1_op2_i;
   logic [3:0]        alu_aluop_o;
   logic [DATA_W-1:0] alu_op1_o, alu_op2_o;
   logic              alu_shift_o;
   logic [DATA_W-1:0] alu_result_i;
   logic              alu_lt_i, alu_ltu_i, alu_zero_i;
   logic              rsp_valid_o, rsp_id_o, rsp_ready_i;
   logic [DATA_W-1:0] rsp_result_o;
   logic [2:0]        rsp_flags_o;
`ifdef YSYX_22040895_ALU_ARB_STAT_EN
   logic [CNT_W-1:0]  stat_grant0_o, stat_grant1_o, stat_stall_o;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   ysyx_22040895_alu_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_aluop_i(req0_aluop_i), .req0_op1_i(req0_op1_i),
      .req0_op2_i(req0_op2_i), .req0_shift_i(req0_shift_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_aluop_i(req1_aluop_i), .req1_op1_i(req1_op1_i),
      .req1_op2_i(req1_op2_i), .req1_shift_i(req1_shift_i),
      .alu_aluop_o(alu_aluop_o), .alu_op1_o(alu_op1_o),
      .alu_op2_o(alu_op2_o), .alu_shift_o(alu_shift_o),
      .alu_result_i(alu_result_i), .alu_lt_i(alu_lt_i),
      .alu_ltu_i(alu_ltu_i), .alu_zero_i(alu_zero_i),
      .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
      .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
      .rsp_ready_i(rsp_ready_i)
`ifdef YSYX_22040895_ALU_ARB_STAT_EN
      ,
      .stat_grant0_o(stat_grant0_o), .stat_grant1_o(stat_grant1_o),
      .stat_stall_o(stat_stall_o)
`endif
   );

   // ALU model: compare flags are only produced by slt/sltu.
   always_comb begin
      case (alu_aluop_o)
         4'b0000: alu_result_i = alu_op1_o + alu_op2_o;
         4'b0001: alu_result_i = alu_op1_o - alu_op2_o;
         4'b0010: alu_result_i = {63'd0, $signed(alu_op1_o) < $signed(alu_op2_o)};
         4'b1001: alu_result_i = {63'd0, alu_op1_o < alu_op2_o};
         4'b0011: alu_result_i = alu_op1_o << alu_op2_o[5:0];
         4'b0100: alu_result_i = alu_op1_o >> alu_op2_o[5:0];
         4'b0101: alu_result_i = $signed(alu_op1_o) >>> alu_op2_o[5:0];
         4'b0110: alu_result_i = alu_op1_o & alu_op2_o;
         4'b0111: alu_result_i = alu_op1_o | alu_op2_o;
         4'b1000: alu_result_i = alu_op1_o ^ alu_op2_o;
         default: alu_result_i = '0;
      endcase
      alu_lt_i   = (alu_aluop_o == 4'b0010) && ($signed(alu_op1_o) < $signed(alu_op2_o));
      alu_ltu_i  = (alu_aluop_o == 4'b1001) && (alu_op1_o < alu_op2_o);
      alu_zero_i = (alu_result_i == '0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic sh);
      req0_valid_i = v; req0_aluop_i = op; req0_op1_i = a; req0_op2_i = b; req0_shift_i = sh;
   endtask

   task automatic drive1(input logic v, input logic [3:0] op,
                         input logic [63:0] a, input logic [63:0] b, input logic sh);
      req1_valid_i = v; req1_aluop_i = op; req1_op1_i = a; req1_op2_i = b; req1_shift_i = sh;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rsp_ready_i = 1'b1;
      drive0(1'b1, 4'h0, 64'd1, 64'd1, 1'b0);
      drive1(1'b1, 4'h0, 64'd2, 64'd2, 1'b0);
      tick();
      tick();
      @(negedge clk);
      tests++;
      if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_ready: got %b%b expected 00", req0_ready_o, req1_ready_o);
      end
      tests++;
      if ({rsp_valid_o, rsp_id_o, rsp_flags_o} !== 5'b0 || rsp_result_o !== 64'd0) begin
         fails++;
         $display("FAIL reset_rsp: got v%b id%b fl%b res%h expected all zero",
                  rsp_valid_o, rsp_id_o, rsp_flags_o, rsp_result_o);
      end
      drive0(1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
      drive1(1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_add();
      apply_reset();
      rsp_ready_i = 1'b1;
      drive0(1'b1, 4'h0, 64'd5, 64'd7, 1'b0);
      @(negedge clk);
      tests++;
      if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0 || alu_op1_o !== 64'd5) begin
         fails++;
         $display("FAIL add_grant: got r%b%b op1 %0d expected 10 op1 5",
                  req0_ready_o, req1_ready_o, alu_op1_o);
      end
      tick();
      req0_valid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b0 || rsp_result_o !== 64'd12 ||
          rsp_flags_o !== 3'b000) begin
         fails++;
         $display("FAIL add_rsp: got v%b id%b res%0d fl%b expected v1 id0 res12 fl000",
                  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o);
      end
      tick();
      @(negedge clk);
      tests++;
      if (rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL add_drain: got v%b expected 0", rsp_valid_o);
      end
   endtask

   task automatic test_round_robin();
      logic [63:0] exp_res;
      apply_reset();
      rsp_ready_i = 1'b1;
      drive0(1'b1, 4'h0, 64'd10, 64'd1, 1'b0);
      drive1(1'b1, 4'h8, 64'd6, 64'd3, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests++;
         if (req0_ready_o !== ((k % 2) == 0) || req1_ready_o !== ((k % 2) == 1)) begin
            fails++;
            $display("FAIL rr_grant%0d: got r%b%b expected r%b%b", k,
                     req0_ready_o, req1_ready_o, (k % 2) == 0, (k % 2) == 1);
         end
         if (k > 0) begin
            exp_res = (((k - 1) % 2) == 0) ? 64'd11 : 64'd5;
            tests++;
            if (rsp_id_o !== (((k - 1) % 2) == 1) || rsp_result_o !== exp_res) begin
               fails++;
               $display("FAIL rr_rsp%0d: got id%b res%0d expected id%b res%0d", k,
                        rsp_id_o, rsp_result_o, ((k - 1) % 2) == 1, exp_res);
            end
         end
         tick();
      end
      drive0(1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
      drive1(1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
      @(negedge clk);
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 || rsp_result_o !== 64'd5) begin
         fails++;
         $display("FAIL rr_last: got v%b id%b res%0d expected v1 id1 res5",
                  rsp_valid_o, rsp_id_o, rsp_result_o);
      end
   endtask

   task automatic test_backpressure();
      tick();
      rsp_ready_i = 1'b1;
      drive1(1'b1, 4'h1, 64'd3, 64'd3, 1'b0);
      @(negedge clk);
      tests++;
      if (req1_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL bp_fill: got r1=%b expected 1", req1_ready_o);
      end
      tick();
      req1_valid_i = 1'b0;
      rsp_ready_i  = 1'b0;
      drive0(1'b1, 4'h7, 64'hF0, 64'h0F, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++;
         if (req0_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 ||
             rsp_result_o !== 64'd0 || rsp_flags_o !== 3'b001) begin
            fails++;
            $display("FAIL bp_hold%0d: got r0%b v%b id%b res%0d fl%b expected r00 v1 id1 res0 fl001",
                     k, req0_ready_o, rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o);
         end
         tick();
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      tests++;
      if (req0_ready_o !== 1'b1 || rsp_id_o !== 1'b1) begin
         fails++;
         $display("FAIL bp_release: got r0%b id%b expected r01 id1", req0_ready_o, rsp_id_o);
      end
      tick();
      req0_valid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b0 || rsp_result_o !== 64'hFF ||
          rsp_flags_o !== 3'b000) begin
         fails++;
         $display("FAIL bp_after: got v%b id%b res%h fl%b expected v1 id0 res ff fl000",
                  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_flags_o);
      end
   endtask

   task automatic test_flags();
      tick();
      drive1(1'b1, 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      @(negedge clk);
      tests++;
      if (req1_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL slt_grant: got r1=%b expected 1", req1_ready_o);
      end
      tick();
      req1_valid_i = 1'b0;
      drive0(1'b1, 4'h9, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      @(negedge clk);
      tests++;
      if (rsp_id_o !== 1'b1 || rsp_result_o !== 64'd1 || rsp_flags_o !== 3'b100) begin
         fails++;
         $display("FAIL slt_rsp: got id%b res%0d fl%b expected id1 res1 fl100",
                  rsp_id_o, rsp_result_o, rsp_flags_o);
      end
      tick();
      drive0(1'b1, 4'h5, 64'h8000_0000_0000_0000, 64'd4, 1'b1);
      @(negedge clk);
      tests++;
      if (rsp_id_o !== 1'b0 || rsp_result_o !== 64'd1 || rsp_flags_o !== 3'b010 ||
          alu_shift_o !== 1'b1) begin
         fails++;
         $display("FAIL sltu_rsp: got id%b res%0d fl%b sh%b expected id0 res1 fl010 sh1",
                  rsp_id_o, rsp_result_o, rsp_flags_o, alu_shift_o);
      end
      tick();
      req0_valid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (rsp_result_o !== 64'hF800_0000_0000_0000 || rsp_flags_o !== 3'b000) begin
         fails++;
         $display("FAIL sra_rsp: got res%h fl%b expected f800000000000000 fl000",
                  rsp_result_o, rsp_flags_o);
      end
      tests++;
      if (alu_aluop_o !== 4'h0 || alu_op1_o !== 64'd0 || alu_op2_o !== 64'd0 ||
          alu_shift_o !== 1'b0) begin
         fails++;
         $display("FAIL idle_alu: got op%h a%h b%h sh%b expected all zero",
                  alu_aluop_o, alu_op1_o, alu_op2_o, alu_shift_o);
      end
   endtask

   task automatic test_reset_mid();
      tick();
      rsp_ready_i = 1'b0;
      drive0(1'b1, 4'h0, 64'd1, 64'd2, 1'b0);
      tick();
      rst = 1'b1;
      drive1(1'b1, 4'h0, 64'd9, 64'd9, 1'b0);
      @(negedge clk);
      tests++;
      if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0 || rsp_valid_o !== 1'b1) begin
         fails++;
         $display("FAIL rstmid_pre: got r%b%b v%b expected r00 v1",
                  req0_ready_o, req1_ready_o, rsp_valid_o);
      end
      tick();
      rst = 1'b0;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      tests++;
      if (rsp_valid_o !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_drop: got v%b expected 0", rsp_valid_o);
      end
      tests++;
      if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_first: got r%b%b expected r10", req0_ready_o, req1_ready_o);
      end
      tick();
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b0 || rsp_result_o !== 64'd3) begin
         fails++;
         $display("FAIL rstmid_rsp: got v%b id%b res%0d expected v1 id0 res3",
                  rsp_valid_o, rsp_id_o, rsp_result_o);
      end
   endtask

`ifdef YSYX_22040895_ALU_ARB_STAT_EN
   task automatic test_stats();
      apply_reset();
      rsp_ready_i = 1'b1;
      drive0(1'b1, 4'h0, 64'd1, 64'd1, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      rsp_ready_i = 1'b0;
      for (int k = 0; k < 2; k++) tick();
      req0_valid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (stat_grant0_o !== 32'd5 || stat_grant1_o !== 32'd0 || stat_stall_o !== 32'd2) begin
         fails++;
         $display("FAIL stats: got g0=%0d g1=%0d st=%0d expected 5 0 2",
                  stat_grant0_o, stat_grant1_o, stat_stall_o);
      end
      rsp_ready_i = 1'b1;
      tick();
   endtask
`endif

   initial begin
      rst = 1'b1;
      rsp_ready_i = 1'b0;
      drive0(1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
      drive1(1'b0, 4'h0, 64'd0, 64'd0, 1'b0);
      test_reset();
      test_single_add();
      test_round_robin();
      test_backpressure();
      test_flags();
      test_reset_mid();
`ifdef YSYX_22040895_ALU_ARB_STAT_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ysyx_22040895_alu_arbiter.md
# ysyx_22040895_alu_arbiter

Shares the single combinational `ysyx_22040895_alu` between two requesters: requester 0 (EXU integer ops) and requester 1 (branch/compare unit). Each cycle it grants at most one requester by round-robin, drives that request onto the ALU ports, and captures the ALU outputs into a one-entry response register tagged with the winner's id. The block sits between the issue logic and the ALU. Full throughput is one operation per cycle with one cycle of latency.

## Interface
- `DATA_W`, 64: operand and result width; must match the ALU's `RegBus`.
- `CNT_W`, 32: width of the statistics counters, present only with `YSYX_22040895_ALU_ARB_STAT_EN`.

- `clk` input 1: the only clock; every flop is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid_i` input 1: requester 0 has an operation.
- `req0_ready_o` output 1: requester 0 is granted this cycle.
- `req0_aluop_i` input 4: ALU opcode (0000 add, 0001 sub, 0010 slt, 1001 sltu, 0011 sll, 0100 srl, 0101 sra, 0110 and, 0111 or, 1000 xor).
- `req0_op1_i` / `req0_op2_i` input DATA_W: operands.
- `req0_shift_i` input 1: ALU shift-mode select, passed through unchanged.
- `req1_*`: identical set for requester 1.
- `alu_aluop_o` output 4, `alu_op1_o` / `alu_op2_o` output DATA_W, `alu_shift_o` output 1: drive the ALU inputs.
- `alu_result_i` input DATA_W, `alu_lt_i` input 1, `alu_ltu_i` input 1, `alu_zero_i` input 1: ALU outputs, sampled the same cycle they are driven.
- `rsp_valid_o` output 1: the response register holds a result.
- `rsp_id_o` output 1: the requester that owns the result.
- `rsp_result_o` output DATA_W: captured result.
- `rsp_flags_o` output 3: captured {lt, ltu, zero}.
- `rsp_ready_i` input 1: the consumer accepts the response.

## Operation
- Handshake:
  - A request transfers when `reqN_valid_i && reqN_ready_o`.
  - A response transfers when `rsp_valid_o && rsp_ready_i`.
  - A requester holds its payload stable while it is valid and not ready.
  - `reqN_valid_i` never depends combinationally on `reqN_ready_o`.
- Slot free condition: `slot_free = !rsp_valid_o || rsp_ready_i`. This gives a pass-through drain: the arbiter issues in the same cycle the old response leaves.
- Arbitration:
  - The block grants only when `slot_free` is high.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester other than `last_grant` is granted.
  - `last_grant` updates only on a grant. Its reset value is 1, so requester 0 wins the first conflict.
  - At most one `reqN_ready_o` is high per cycle.
- ALU drive:
  - The granted request's aluop, op1, op2 and shift drive the ALU combinationally.
  - With no grant, the ALU inputs are driven to all-zero (aluop 0000, operands 0, shift 0) so the ALU output is deterministic.
- Response register behaviour:
  - On a grant it loads `alu_result_i`, {`alu_lt_i`, `alu_ltu_i`, `alu_zero_i`} and the grant id, and sets `rsp_valid_o`.
  - On a drain with no grant it clears `rsp_valid_o`.
  - On drain and grant in the same cycle it reloads and `rsp_valid_o` stays high.
  - With no drain and no grant it holds all contents.
- State machine (encoded by `rsp_valid_o`):
  - EMPTY → FULL on a grant.
  - FULL → FULL on hold, or on drain plus grant.
  - FULL → EMPTY on drain without grant.
- The block adds no arithmetic. Result width and flags come straight from the ALU.

## Timing
- Latency: a grant in cycle N gives `rsp_valid_o` high in cycle N+1 with that cycle's ALU result.
- Throughput: one operation per cycle while `rsp_ready_i` is held high.
- Backpressure: with FULL and `rsp_ready_i` low, both `reqN_ready_o` are 0 and the response is held unchanged.
- Reset values, taking effect on the next edge with `rst` high:
  - `rsp_valid_o` = 0, `rsp_id_o` = 0, `rsp_result_o` = 0, `rsp_flags_o` = 0.
  - `last_grant` = 1; counters = 0.
- `reqN_ready_o` is 0 while `rst` is high.
- A reset mid-operation discards any pending response. It is not delivered.
- Simultaneous events: a drain, a grant and a conflict can all occur in one cycle. The response reloads and the pointer flips.

## Configuration
- `YSYX_22040895_ALU_ARB_STAT_EN` defined adds three output ports, each CNT_W wide:
  - `stat_grant0_o`: increments on each requester 0 grant.
  - `stat_grant1_o`: increments on each requester 1 grant.
  - `stat_stall_o`: increments each cycle where any `reqN_valid_i` is high and no grant is made because the slot is full.
- All three counters wrap modulo 2^CNT_W and clear on `rst`.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Single add: req0 {0000, 5, 7} valid, `rsp_ready_i` = 1 → `req0_ready_o` = 1 in cycle 0; in cycle 1 `rsp_valid_o` = 1, id 0, result 12, flags 000.
- Conflict round-robin: both requesters valid for 4 cycles with `rsp_ready_i` = 1 → grants go 0, 1, 0, 1 and `rsp_id_o` follows one cycle later.
- Backpressure: fill the slot with req1 sub {0001, 3, 3}, then hold `rsp_ready_i` = 0 for 3 cycles with req0 valid → the response is held (result 0, flags 001) and `req0_ready_o` = 0; on release, drain and the req0 grant happen in the same cycle.
- Flags: req1 slt {0010, 0xFFFF_FFFF_FFFF_FFFF, 1} → result 1, lt = 1, ltu = 0, zero = 0.
- Reset mid-operation: assert `rst` while FULL → the next cycle has `rsp_valid_o` = 0; after release, both valid → req0 is granted first.
- Stats (macro on): 5 req0 grants, then 2 stalled cycles → `stat_grant0_o` = 5, `stat_stall_o` = 2; preload CNT_W=4 at 15 and grant once → the counter wraps to 0.
